reg_file_mp_sb: RTL and testbench

- Parametrised multi-port register file for the ARM pipeline.
- Adds configurable width and depth, N read ports and M write ports, and same-cycle write-to-read bypass.
- Adds a per-register scoreboard: busy bits are set at issue and cleared at writeback, and a hazard flag is produced per read port.
- Sits between ID (reads, issue) and WB (writes); the hazard unit consumes the rd_hazard flags.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/reg_file_mp_sb.sv | 81 ++++++++
 tb/tb_reg_file_mp_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with scoreboard.
// Optional feature macro used by the top level: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 16;

  // Never returns 0, so a width derived from it is always legal.
  function automatic int clog2_safe(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  typedef logic [clog2_safe(DEFAULT_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, with an
// incrementally maintained population count of busy registers.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = clog2_safe(NUM_REGS),
  parameter int NUM_WR   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic [NUM_REGS-1:0]      busy_vec_o,
  output logic [ADDR_W:0]          busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_vec, set_vec;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     rise_cnt, fall_cnt;

  // A new producer outranks a retiring one, so set beats clear.
  always_comb begin
    clr_vec  = '0;
    set_vec  = '0;
    busy_d   = '0;
    rise_cnt = '0;
    fall_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)))
          clr_vec[r] = 1'b1;
      end
      set_vec[r] = iss_en_i && (iss_addr_i == ADDR_W'(r));
      busy_d[r]  = set_vec[r] | (busy_q[r] & ~clr_vec[r]);
      if (busy_d[r] && !busy_q[r]) rise_cnt = rise_cnt + (ADDR_W+1)'(1);
      if (!busy_d[r] && busy_q[r]) fall_cnt = fall_cnt + (ADDR_W+1)'(1);
    end
    cnt_d = cnt_q + rise_cnt - fall_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-port register file with highest-port-wins writes, optional same-cycle
// write-to-read bypass (macro REGFILE_BYPASS_EN) and a busy-bit scoreboard.
module reg_file_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = clog2_safe(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_hazard,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic [NUM_RD-1:0] rd_hit;

  // Ascending port order lets the highest-indexed enabled port win.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k])
        mem_d[wr_addr[k*ADDR_W +: ADDR_W]] = wr_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data   = '0;
    rd_hazard = '0;
    rd_hit    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
          rd_hit[i] = 1'b1;
        end
      end
`endif
      // A register being written back now is covered by the bypass, not a hazard.
      rd_hazard[i] = busy_vec[rd_addr[i*ADDR_W +: ADDR_W]] & ~rd_hit[i];
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .busy_vec_o (busy_vec),
    .busy_cnt_o (busy_cnt)
  );

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Bench for reg_file_mp_sb: directed scenarios plus randomized traffic against
// an array/queue-level reference model; behaviour follows REGFILE_BYPASS_EN.
module tb_reg_file_mp_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 3;
  localparam int NWR = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_hazard;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [NR-1:0]     busy_vec;
  logic [AW:0]       busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];

  always #5 clk = ~clk;

  reg_file_mp_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_hazard (rd_hazard),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] rd_port(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int r = 0; r < NR; r++) c += m_busy[r];
    return c;
  endfunction

  function automatic logic [NR-1:0] model_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Advance one clock, applying the architectural rules to the model at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NR; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k]) m_mem[wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
      for (int k = 0; k < NWR; k++)
        if (wr_en[k]) m_busy[wr_addr[k*AW +: AW]] = 1'b0;
      if (iss_en) m_busy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic compare_model();
    for (int i = 0; i < NRD; i++) begin
      int a = int'(rd_addr[i*AW +: AW]);
      logic [DW-1:0] exp_d = m_mem[a];
      bit hit = 1'b0;
      if (BYP) begin
        for (int k = NWR - 1; k >= 0 && !hit; k--) begin
          if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) begin
            exp_d = wr_data[k*DW +: DW];
            hit = 1'b1;
          end
        end
      end
      check($sformatf("rnd_rd_data%0d", i), rd_port(i), exp_d);
      check($sformatf("rnd_hazard%0d", i), rd_hazard[i], m_busy[a] && !hit);
    end
    check("rnd_busy_vec", busy_vec, model_vec());
    check("rnd_busy_cnt", busy_cnt, model_cnt());
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    idle();
    #4;
    check("rst_busy_vec", busy_vec, 0);
    check("rst_busy_cnt", busy_cnt, 0);
    set_rd(0, 5);
    #1;
    check("rst_r5", rd_port(0), 0);

    // Reset clears a written register and dominates a same-cycle write.
    idle(); set_wr(0, 5, 32'hDEADBEEF); tick();
    idle(); set_rd(0, 5); #1;
    check("wr_r5", rd_port(0), 32'hDEADBEEF);
    rst = 1'b1; set_wr(0, 5, 32'h1234_5678); iss_en = 1'b1; iss_addr = 5'd9; tick();
    idle(); set_rd(0, 5); #1;
    check("rst_dom_r5", rd_port(0), 0);
    check("rst_dom_busy_vec", busy_vec, 0);
    check("rst_dom_busy_cnt", busy_cnt, 0);

    // Write conflict on r3: port 1 wins.
    idle(); set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(1, 3); #1;
    check("conflict_byp", rd_port(1), BYP ? 32'h22 : 32'h0);
    tick();
    idle(); set_rd(1, 3); #1;
    check("conflict_r3", rd_port(1), 32'h22);

    // Bypass of r7.
    idle(); set_wr(0, 7, 32'h5); tick();
    idle(); set_wr(0, 7, 32'h9); set_rd(0, 7); set_rd(2, 7); #1;
    check("byp_r7_p0", rd_port(0), BYP ? 32'h9 : 32'h5);
    check("byp_r7_p2", rd_port(2), BYP ? 32'h9 : 32'h5);
    tick();
    idle(); set_rd(0, 7); #1;
    check("byp_r7_after", rd_port(0), 32'h9);

    // Scoreboard set/clear.
    idle(); iss_en = 1'b1; iss_addr = 5'd2; tick();
    idle(); iss_en = 1'b1; iss_addr = 5'd4; tick();
    idle(); set_rd(0, 2); #1;
    check("sb_busy_vec", busy_vec, 32'h14);
    check("sb_busy_cnt", busy_cnt, 2);
    check("sb_hazard_r2", rd_hazard[0], 1);
    set_wr(1, 2, 32'hABCD); #1;
    check("sb_wb_hazard", rd_hazard[0], BYP ? 1'b0 : 1'b1);
    tick();
    idle(); #1;
    check("sb_after_wb_cnt", busy_cnt, 1);
    check("sb_after_wb_vec", busy_vec, 32'h10);

    // Issue and writeback of busy r4 together; then re-issue; then write a free reg.
    idle(); iss_en = 1'b1; iss_addr = 5'd4; set_wr(0, 4, 32'h44); tick();
    idle(); #1;
    check("sb_set_clr_vec", busy_vec, 32'h10);
    check("sb_set_clr_cnt", busy_cnt, 1);
    iss_en = 1'b1; iss_addr = 5'd4; tick();
    idle(); #1;
    check("sb_reissue_cnt", busy_cnt, 1);
    set_wr(0, 9, 32'h99); tick();
    idle(); #1;
    check("sb_free_wr_vec", busy_vec, 32'h10);
    check("sb_free_wr_cnt", busy_cnt, 1);

    // Two registers retiring in one cycle.
    iss_en = 1'b1; iss_addr = 5'd11; tick();
    idle(); set_wr(0, 4, 32'h1); set_wr(1, 11, 32'h2); tick();
    idle(); #1;
    check("sb_dual_clr_cnt", busy_cnt, 0);
    check("sb_dual_clr_vec", busy_vec, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      idle();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NWR; k++) begin
        wr_en[k] = $urandom_range(0, 1);
        wr_addr[k*AW +: AW] = AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
        wr_data[k*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      #3;
      compare_model();
      tick();
    end
    idle(); #1;
    compare_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
